fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. It reads the current instruction address, issues reads to the single-cycle program memory, and assembles one- or two-byte instructions into an instruction register. It pulses the counter's write-enable once per byte consumed and presents each complete instruction to decode through a valid/ready handshake. Branch redirects discard any in-flight fetch through a flush input.

## Interface
- ADDR_W, 8, program address width
- DATA_W, 8, program memory word width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  current instruction address from program counter; reflects pc+1 the cycle after pc_adv
- pc_adv  out  1  one-cycle advance pulse, drives counter write-enable
- mem_rd  out  1  program memory read strobe
- mem_addr  out  ADDR_W  program memory address (equals pc whenever mem_rd=1)
- mem_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd
- flush  in  1  branch redirect; abort current fetch
- ir_valid  out  1  instruction register holds a complete instruction
- ir_ready  in  1  decode accepts instruction
- ir_opcode  out  DATA_W  opcode byte
- ir_operand  out  DATA_W  operand byte (0 for one-byte instructions)
- ir_two_byte  out  1  instruction carries an operand
- ir_addr  out  ADDR_W  address of opcode byte

## Operation
- States: F_OP, W_OP, W_ARG, HOLD.
- F_OP: mem_rd=1, mem_addr=pc, pc_adv=1; latch pc into ir_addr; -> W_OP.
- W_OP: capture mem_data into ir_opcode. If mem_data[OPERAND_BIT]=1: ir_two_byte<=1, mem_rd=1, mem_addr=pc (already incremented), pc_adv=1, -> W_ARG. Else ir_two_byte<=0, ir_operand<=0, -> HOLD.
- W_ARG: capture mem_data into ir_operand; -> HOLD.
- HOLD: ir_valid=1; ir_opcode/ir_operand/ir_two_byte/ir_addr stable. On ir_ready=1 -> F_OP; else stay (unbounded stall).
- mem_rd and pc_adv are combinational from state and forced 0 while rst=1 or flush=1.
- flush=1 in any state: next state F_OP, ir_valid=0 next cycle, returning mem_data ignored, no pc_adv that cycle. flush and ir_ready together in HOLD: flush wins, instruction counts as dropped.
- Reset: state F_OP; ir_valid, ir_opcode, ir_operand, ir_two_byte, ir_addr all 0. First mem_rd in the first cycle with rst=0.
- Address wrap: opcode at 0xFF with operand reads operand at 0x00 (counter wraps); ir_addr=0xFF.
- ir_valid never asserted in F_OP, W_OP, W_ARG.

## Timing
- One-byte: F_OP at cycle t, ir_valid=1 at t+2.
- Two-byte: ir_valid=1 at t+3.
- Handshake at cycle h (ir_valid & ir_ready): ir_valid=0 at h+1, next F_OP at h+1.
- Steady-state throughput: 1 instruction / 3 cycles (one-byte), / 4 cycles (two-byte), with ir_ready held high.
- Exactly one pc_adv pulse per byte fetched; none during stall, flush or reset.

## Structure
- Shared package cpu_pkg: fetch_state_t enum {F_OP, W_OP, W_ARG, HOLD}; OPERAND_BIT = 7; ADDR_W/DATA_W default constants.
- Single FSM plus instruction-register flops in one module; no sub-module warranted.

## Test plan
- Reset then memory {0x00:0x12}: mem_rd at cycle 0 addr 0x00, ir_valid at cycle 2, opcode 0x12, operand 0x00, two_byte 0, ir_addr 0x00, one pc_adv.
- Memory {0x05:0x83, 0x06:0x4A}, pc=0x05: ir_valid at t+3, opcode 0x83, operand 0x4A, two_byte 1, ir_addr 0x05, two pc_adv pulses, pc=0x07 afterwards.
- ir_ready low for 10 cycles in HOLD: outputs stable, no mem_rd or pc_adv; ready high -> ir_valid drops next cycle, new F_OP issues.
- flush asserted in W_ARG: operand data ignored, ir_valid stays 0, next cycle F_OP fetches at new pc (e.g. 0x40) with single pc_adv.
- Two-byte opcode 0x90 at 0xFF: operand read from 0x00, ir_addr 0xFF, pc=0x01 afterwards.
- rst asserted mid-W_OP: mem_rd/pc_adv 0 during rst, all ir_* outputs 0 next cycle, fetch restarts at F_OP after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and the fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned OPERAND_BIT = 7;

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    W_OP  = 2'd1,
    W_ARG = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one- or two-byte instructions from single-cycle program
// memory, advances the program counter per byte, and hands the result to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic              ir_two_byte,
  output logic [ADDR_W-1:0] ir_addr
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic has_operand;

  assign has_operand = mem_data[OPERAND_BIT];

  // Memory is always addressed by the counter; the strobe qualifies it.
  assign mem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_OP;
    end else begin
      state <= next_state;
    end
  end

  // Next state and read/advance strobes
  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    pc_adv     = 1'b0;
    case (state)
      F_OP: begin
        mem_rd     = 1'b1;
        pc_adv     = 1'b1;
        next_state = W_OP;
      end
      W_OP: begin
        if (has_operand) begin
          mem_rd     = 1'b1;
          pc_adv     = 1'b1;
          next_state = W_ARG;
        end else begin
          next_state = HOLD;
        end
      end
      W_ARG: next_state = HOLD;
      HOLD: begin
        if (ir_ready) begin
          next_state = F_OP;
        end
      end
      default: next_state = F_OP;
    endcase
    // A redirect or reset abandons the fetch and suppresses any counter advance.
    if (rst || flush) begin
      mem_rd     = 1'b0;
      pc_adv     = 1'b0;
      next_state = F_OP;
    end
  end

  // Instruction register; returning data is discarded on a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_valid    <= 1'b0;
      ir_opcode   <= '0;
      ir_operand  <= '0;
      ir_two_byte <= 1'b0;
      ir_addr     <= '0;
    end else begin
      ir_valid <= (next_state == HOLD);
      if (!flush) begin
        case (state)
          F_OP: ir_addr <= pc;
          W_OP: begin
            ir_opcode   <= mem_data;
            ir_two_byte <= has_operand;
            if (!has_operand) begin
              ir_operand <= '0;
            end
          end
          W_ARG:   ir_operand <= mem_data;
          default: ;
        endcase
      end
    end
  end

endmodule
